// File: rtl/pad_mode_sequencer.sv
// Staggered pad enable after power-good, then break-before-make digital/analog switching of one pad at a time.
// Optional: `define PAD_SEQ_LOCK_EN rejects analog requests to pads set in LOCK_MASK.
module pad_mode_sequencer #(
    parameter int                  NUM_PADS   = 38,
    parameter int                  GROUP_SIZE = 8,
    parameter int                  STAGGER    = 8,
    parameter int                  SETTLE     = 4,
    parameter logic [NUM_PADS-1:0] LOCK_MASK  = {NUM_PADS{1'b0}}
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        porb,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(NUM_PADS)-1:0] req_pad,
    input  logic                        req_analog,
    input  logic [NUM_PADS-1:0]         core_oeb,
    output logic [NUM_PADS-1:0]         pad_enh,
    output logic [NUM_PADS-1:0]         pad_oeb,
    output logic [NUM_PADS-1:0]         pad_inp_dis,
    output logic [NUM_PADS-1:0]         pad_analog_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int PW   = $clog2(NUM_PADS);
    localparam int G    = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int CMAX = (STAGGER > 2 * SETTLE) ? STAGGER : 2 * SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

`ifdef PAD_SEQ_LOCK_EN
    localparam logic LOCK_ON = 1'b1;
`else
    localparam logic LOCK_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_WAIT_POR,
        ST_STAGGER,
        ST_READY,
        ST_ISOLATE,
        ST_SWITCH,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grp_q, grp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         pad_q, pad_d;
    logic                  tgt_q, tgt_d;
    logic [NUM_PADS-1:0]   enh_q, enh_d;
    logic [NUM_PADS-1:0]   ana_q, ana_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  req_oor;
    logic                  req_locked;
    logic                  iso_act;
    logic [NUM_PADS-1:0]   iso;

    function automatic logic [NUM_PADS-1:0] group_mask(input logic [GW-1:0] g);
        logic [NUM_PADS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            m[i] = ((i / GROUP_SIZE) == int'(g));
        end
        return m;
    endfunction

    assign req_oor    = (int'(req_pad) >= NUM_PADS);
    assign req_locked = LOCK_ON & req_analog & LOCK_MASK[req_pad];

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        cnt_d   = cnt_q;
        pad_d   = pad_q;
        tgt_d   = tgt_q;
        enh_d   = enh_q;
        ana_d   = ana_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Loss of power-good overrides everything, including a same-cycle handshake.
        if (!porb) begin
            state_d = ST_WAIT_POR;
            grp_d   = '0;
            cnt_d   = '0;
            enh_d   = '0;
            ana_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_POR: begin
                    state_d = ST_STAGGER;
                    grp_d   = '0;
                    cnt_d   = '0;
                    enh_d   = group_mask('0);
                end
                ST_STAGGER: begin
                    if (grp_q == GW'(G - 1)) begin
                        state_d = ST_READY;
                    end else if (cnt_q == CW'(STAGGER - 1)) begin
                        grp_d = grp_q + 1'b1;
                        cnt_d = '0;
                        enh_d = enh_q | group_mask(grp_q + 1'b1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (req_valid) begin
                        if (req_oor || req_locked) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end else if (req_analog == ana_q[req_pad]) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_ISOLATE;
                            pad_d   = req_pad;
                            tgt_d   = req_analog;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_ISOLATE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        state_d      = ST_SWITCH;
                        ana_d[pad_q] = tgt_q;
                    end
                end
                ST_SWITCH, ST_RELEASE: begin
                    // One counter spans the whole isolation window so SETTLE=1 needs no special case.
                    if (cnt_q == CW'(2 * SETTLE - 1)) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WAIT_POR;
                    enh_d   = '0;
                    ana_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WAIT_POR;
            grp_q   <= '0;
            cnt_q   <= '0;
            pad_q   <= '0;
            tgt_q   <= 1'b0;
            enh_q   <= '0;
            ana_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            tgt_q   <= tgt_d;
            enh_q   <= enh_d;
            ana_q   <= ana_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        iso_act = (state_q == ST_ISOLATE) || (state_q == ST_SWITCH) || (state_q == ST_RELEASE);
        iso     = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            iso[i] = iso_act && (int'(pad_q) == i);
        end
    end

    assign pad_enh       = enh_q;
    assign pad_analog_en = ana_q;
    assign pad_oeb       = core_oeb | iso | ~enh_q | ana_q;
    assign pad_inp_dis   = iso | ~enh_q | ana_q;
    assign req_ready     = (state_q == ST_READY);
    assign busy          = (state_q != ST_READY);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pad_mode_sequencer.sv
// Scoreboarded bench for pad_mode_sequencer: stagger timing, isolation windows, edge requests, porb loss, random traffic.
module tb_pad_mode_sequencer;

    localparam int NP = 38;
    localparam int GS = 8;
    localparam int ST = 8;
    localparam int SE = 4;
    localparam int G  = (NP + GS - 1) / GS;
    localparam logic [NP-1:0] LM = 38'h4;
`ifdef PAD_SEQ_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          porb;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_pad;
    logic          req_analog;
    logic [NP-1:0] core_oeb;
    logic [NP-1:0] pad_enh;
    logic [NP-1:0] pad_oeb;
    logic [NP-1:0] pad_inp_dis;
    logic [NP-1:0] pad_analog_en;
    logic          busy;
    logic          done;
    logic          err;

    pad_mode_sequencer #(
        .NUM_PADS  (NP),
        .GROUP_SIZE(GS),
        .STAGGER   (ST),
        .SETTLE    (SE),
        .LOCK_MASK (LM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .porb         (porb),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pad      (req_pad),
        .req_analog   (req_analog),
        .core_oeb     (core_oeb),
        .pad_enh      (pad_enh),
        .pad_oeb      (pad_oeb),
        .pad_inp_dis  (pad_inp_dis),
        .pad_analog_en(pad_analog_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            t;
        bit            e;
        logic [NP-1:0] ana;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [NP-1:0] model_ana = '0;
    logic [NP-1:0] all_ones  = '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 err=%0b, expected no done", cyc, err);
            end else begin
                mon_e = sbq.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.t));
                check("done_err", err, mon_e.e);
                check("done_analog_en", pad_analog_en, mon_e.ana);
            end
        end
    end

    task automatic step();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Called at a negedge; presents the request once req_ready is seen and records the expected outcome.
    task automatic issue(input int pad, input bit analog, output int t);
        int w;
        int lat;
        bit e;
        w = 0;
        while (!req_ready && w < 400) begin
            @(negedge clock);
            w++;
        end
        n_tests++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL ready_timeout pad=%0d: got req_ready=0 after %0d cycles, expected 1", pad, w);
            t = -1;
            return;
        end
        req_valid  = 1'b1;
        req_pad    = 6'(pad);
        req_analog = analog;
        t          = cyc;
        if (pad >= NP) begin
            e = 1'b1; lat = 1;
        end else if (LOCK_ON && analog && LM[pad]) begin
            e = 1'b1; lat = 1;
        end else if (model_ana[pad] == analog) begin
            e = 1'b0; lat = 1;
        end else begin
            e = 1'b0; lat = 2 * SE + 1;
            model_ana[pad] = analog;
        end
        sbq.push_back('{t: t + lat, e: e, ana: model_ana});
    endtask

    task automatic run_stagger();
        int            p;
        logic [NP-1:0] exp_enh;
        logic [NP-1:0] off;
        logic [NP-1:0] oeb_off;
        porb = 1'b1;
        p    = cyc;
        while (cyc < p + (G - 1) * ST + 3) begin
            step();
            for (int i = 0; i < NP; i++) exp_enh[i] = (cyc >= p + 1 + (i / GS) * ST);
            off     = ~exp_enh;
            oeb_off = pad_oeb & off;
            check("stagger_enh", pad_enh, exp_enh);
            check("stagger_oeb_off", oeb_off, off);
            check("stagger_ready", req_ready, (cyc >= p + 2 + (G - 1) * ST));
        end
    endtask

    task automatic directed_change(input int pad, input bit to_analog, input bit oeb_bit);
        int t;
        bit old;
        core_oeb[pad] = oeb_bit;
        old = model_ana[pad];
        issue(pad, to_analog, t);
        for (int c = 1; c <= 2 * SE + 1; c++) begin
            step();
            if (c <= 2 * SE) begin
                check("iso_oeb", pad_oeb[pad], 1);
                check("iso_inp_dis", pad_inp_dis[pad], 1);
                check("iso_busy_ready", {busy, req_ready}, 2'b10);
                check("iso_analog_en", pad_analog_en[pad], (c <= SE) ? old : to_analog);
            end else begin
                check("rel_oeb", pad_oeb[pad], oeb_bit | to_analog);
                check("rel_inp_dis", pad_inp_dis[pad], to_analog);
                check("rel_busy_ready", {busy, req_ready}, 2'b01);
            end
        end
    endtask

    task automatic directed_quick(input int pad, input bit analog);
        int            t;
        logic [NP-1:0] exp_oeb;
        issue(pad, analog, t);
        step();
        exp_oeb = core_oeb | model_ana;
        check("quick_busy_ready", {busy, req_ready}, 2'b01);
        check("quick_analog_en", pad_analog_en, model_ana);
        check("quick_oeb", pad_oeb, exp_oeb);
    endtask

    initial begin
        int t;
        int pad;
        int w;
        reset      = 1'b1;
        porb       = 1'b0;
        req_valid  = 1'b0;
        req_pad    = '0;
        req_analog = 1'b0;
        core_oeb   = {$urandom, $urandom};

        repeat (3) @(negedge clock);
        check("rst_enh", pad_enh, 0);
        check("rst_analog_en", pad_analog_en, 0);
        check("rst_oeb", pad_oeb, all_ones);
        check("rst_inp_dis", pad_inp_dis, all_ones);
        check("rst_ctrl", {req_ready, busy, done, err}, 4'b0100);

        reset = 1'b0;
        repeat (3) step();
        check("wait_por_ctrl", {req_ready, busy, pad_enh}, {2'b01, 38'h0});

        run_stagger();

        directed_change(5, 1'b1, 1'b0);
        directed_change(5, 1'b0, 1'b0);
        directed_quick(40, 1'b1);
        directed_quick(5, 1'b0);
        directed_change(5, 1'b1, 1'b1);
        directed_quick(5, 1'b1);
        directed_change(5, 1'b0, 1'b1);

`ifdef PAD_SEQ_LOCK_EN
        directed_quick(2, 1'b1);
        check("lock_analog_en2", pad_analog_en[2], 0);
`else
        directed_change(2, 1'b1, 1'b0);
        directed_change(2, 1'b0, 1'b0);
`endif

        // porb loss in the middle of a pad 5 sequence.
        issue(5, 1'b1, t);
        repeat (3) step();
        porb = 1'b0;
        void'(sbq.pop_back());
        model_ana = '0;
        step();
        check("drop_enh", pad_enh, 0);
        check("drop_analog_en", pad_analog_en, 0);
        check("drop_oeb", pad_oeb, all_ones);
        check("drop_ctrl", {busy, req_ready}, 2'b10);
        repeat (12) step();
        run_stagger();

        // porb falling together with a handshake: the drop wins.
        req_valid  = 1'b1;
        req_pad    = 6'd7;
        req_analog = 1'b1;
        porb       = 1'b0;
        step();
        check("simul_ctrl", {busy, req_ready}, 2'b10);
        check("simul_analog_en", pad_analog_en, 0);
        repeat (10) step();
        run_stagger();

        for (int n = 0; n < 40; n++) begin
            core_oeb = {$urandom, $urandom};
            pad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(38, 63)) : int'($urandom_range(0, 37));
            if ($urandom_range(0, 3) == 0) pad = 5;
            issue(pad, 1'($urandom_range(0, 1)), t);
            step();
            repeat ($urandom_range(0, 3)) step();
        end

        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            step();
            w++;
        end
        check("drain_outstanding", sbq.size(), 0);

        // Reset during a sequence returns everything to reset values.
        pad = 9;
        issue(pad, ~model_ana[pad], t);
        repeat (2) step();
        reset = 1'b1;
        step();
        sbq.delete();
        model_ana = '0;
        check("midrst_enh", pad_enh, 0);
        check("midrst_analog_en", pad_analog_en, 0);
        check("midrst_inp_dis", pad_inp_dis, all_ones);
        check("midrst_ctrl", {req_ready, busy, done, err}, 4'b0100);
        reset = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
